// File: rtl/cordic_iter_ctrl.sv
// Iterative sequencer for a single combinational CORDIC micro-rotation stage.
// It feeds the registered x/y/z back through the stage for p_ITER steps and issues shift, LUT address and direction.
//   state | meaning
//   IDLE  | ready for an operand set; working registers hold the last result
//   RUN   | one stage evaluation per cycle, results written back each edge
//   DONE  | result presented on o_x/o_y/o_z until downstream accepts
module cordic_iter_ctrl #(
    parameter int p_WIDTH = 16,
    parameter int p_ITER  = 16,
    localparam int p_LOG2_WIDTH = $clog2(p_WIDTH)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [p_WIDTH-1:0]      i_x,
    input  logic [p_WIDTH-1:0]      i_y,
    input  logic [p_WIDTH-1:0]      i_z,
    input  logic                    i_mode,
    input  logic                    i_vector,
    output logic [p_WIDTH-1:0]      o_stage_x,
    output logic [p_WIDTH-1:0]      o_stage_y,
    output logic [p_WIDTH-1:0]      o_stage_z,
    output logic                    o_stage_d,
    output logic                    o_stage_mode,
    output logic [p_LOG2_WIDTH-1:0] o_stage_shift,
    output logic [p_LOG2_WIDTH-1:0] o_lut_addr,
    input  logic [p_WIDTH-1:0]      i_stage_xnext,
    input  logic [p_WIDTH-1:0]      i_stage_ynext,
    input  logic [p_WIDTH-1:0]      i_stage_znext,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [p_WIDTH-1:0]      o_x,
    output logic [p_WIDTH-1:0]      o_y,
    output logic [p_WIDTH-1:0]      o_z,
    output logic                    o_busy
);

    localparam int CNT_W = (p_ITER > 2) ? $clog2(p_ITER) : 1;
    // Two extra bits so the repeat point can hold 3*(p_WIDTH-1)+1.
    localparam int REP_W = p_LOG2_WIDTH + 2;
    localparam logic [p_LOG2_WIDTH-1:0] SHIFT_MAX = p_LOG2_WIDTH'(p_WIDTH - 1);
    localparam logic [CNT_W-1:0]        CNT_LAST  = CNT_W'(p_ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [p_WIDTH-1:0]      r_x;
    logic [p_WIDTH-1:0]      r_y;
    logic [p_WIDTH-1:0]      r_z;
    logic                    r_mode;
    logic                    r_vector;
    logic [CNT_W-1:0]        r_cnt;
    logic [p_LOG2_WIDTH-1:0] r_shift;
    logic [REP_W-1:0]        r_rep;
    logic                    r_rep_again;

    logic                    accept;
    logic                    last_step;
    logic                    at_rep;
    logic [p_LOG2_WIDTH-1:0] shift_step;

    assign accept     = (state_q == IDLE) && i_valid;
    assign last_step  = (state_q == RUN) && (r_cnt == CNT_LAST);
    assign at_rep     = !r_mode && (REP_W'(r_shift) == r_rep);
    assign shift_step = (r_shift == SHIFT_MAX) ? r_shift : r_shift + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (i_valid)   state_d = RUN;
            RUN:  if (last_step) state_d = DONE;
            DONE: if (i_ready)   state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_mode      <= 1'b0;
            r_vector    <= 1'b0;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_rep       <= '0;
            r_rep_again <= 1'b0;
        end else if (accept) begin
            r_x         <= i_x;
            r_y         <= i_y;
            r_z         <= i_z;
            r_mode      <= i_mode;
            r_vector    <= i_vector;
            r_cnt       <= '0;
            r_shift     <= i_mode ? '0 : p_LOG2_WIDTH'(1);
            r_rep       <= REP_W'(4);
            r_rep_again <= 1'b0;
        end else if (state_q == RUN) begin
            r_x   <= i_stage_xnext;
            r_y   <= i_stage_ynext;
            r_z   <= i_stage_znext;
            r_cnt <= r_cnt + 1'b1;
            // Hyperbolic convergence needs the repeat-point shift issued a second time.
            if (at_rep && !r_rep_again) begin
                r_rep_again <= 1'b1;
            end else begin
                r_shift <= shift_step;
                if (at_rep) begin
                    r_rep_again <= 1'b0;
                    r_rep       <= (r_rep << 1) + r_rep + REP_W'(1);
                end
            end
        end
    end

    assign o_ready       = (state_q == IDLE);
    assign o_busy        = (state_q == RUN) || (state_q == DONE);
    assign o_valid       = (state_q == DONE);
    assign o_stage_x     = r_x;
    assign o_stage_y     = r_y;
    assign o_stage_z     = r_z;
    assign o_stage_d     = r_vector ? r_y[p_WIDTH-1] : ~r_z[p_WIDTH-1];
    assign o_stage_mode  = r_mode;
    assign o_stage_shift = r_shift;
    assign o_lut_addr    = r_shift;
    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_z           = r_z;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Bench for cordic_iter_ctrl: behavioural Q2.13 stage, directed scenarios and randomized ops
// checked against an iterative reference model built from the shift/direction rules.
module tb_cordic_iter_ctrl;

    localparam int W = 16;
    localparam int N = 16;
    localparam int LW = $clog2(W);

    localparam logic signed [15:0] ATAN [16] = '{
        16'sd6434, 16'sd3798, 16'sd2007, 16'sd1019, 16'sd511, 16'sd256, 16'sd128, 16'sd64,
        16'sd32,   16'sd16,   16'sd8,    16'sd4,    16'sd2,   16'sd1,   16'sd1,   16'sd0};
    localparam logic signed [15:0] ATANH [16] = '{
        16'sd0,    16'sd4500, 16'sd2092, 16'sd1029, 16'sd513, 16'sd256, 16'sd128, 16'sd64,
        16'sd32,   16'sd16,   16'sd8,    16'sd4,    16'sd2,   16'sd1,   16'sd1,   16'sd0};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_valid, o_ready, i_mode, i_vector, i_ready, o_valid, o_busy;
    logic [W-1:0]  i_x, i_y, i_z, o_x, o_y, o_z;
    logic [W-1:0]  o_stage_x, o_stage_y, o_stage_z, sx, sy, sz;
    logic          o_stage_d, o_stage_mode;
    logic [LW-1:0] o_stage_shift, o_lut_addr;
    logic [47:0]   sres;

    int n_pass = 0;
    int n_total = 0;
    int exp_sh[$];
    int got_sh[$];

    always #5 clk = ~clk;

    cordic_iter_ctrl #(.p_WIDTH(W), .p_ITER(N)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_x(i_x), .i_y(i_y), .i_z(i_z), .i_mode(i_mode), .i_vector(i_vector),
        .o_stage_x(o_stage_x), .o_stage_y(o_stage_y), .o_stage_z(o_stage_z),
        .o_stage_d(o_stage_d), .o_stage_mode(o_stage_mode),
        .o_stage_shift(o_stage_shift), .o_lut_addr(o_lut_addr),
        .i_stage_xnext(sx), .i_stage_ynext(sy), .i_stage_znext(sz),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_x(o_x), .o_y(o_y), .o_z(o_z), .o_busy(o_busy));

    // Micro-rotation: d=1 rotates by +angle (z decreases); hyperbolic flips the x update sign.
    function automatic logic [47:0] stage_f(input logic signed [15:0] x, y, z,
                                            input logic d, m, input logic [3:0] s, a);
        logic signed [15:0] xs, ys, lv, xn, yn, zn;
        xs = x >>> s;
        ys = y >>> s;
        lv = m ? ATAN[a] : ATANH[a];
        if (d) begin
            xn = m ? x - ys : x + ys;
            yn = y + xs;
            zn = z - lv;
        end else begin
            xn = m ? x + ys : x - ys;
            yn = y - xs;
            zn = z + lv;
        end
        return {xn, yn, zn};
    endfunction

    always_comb sres = stage_f(o_stage_x, o_stage_y, o_stage_z, o_stage_d, o_stage_mode,
                               o_stage_shift, o_lut_addr);
    assign sx = sres[47:32];
    assign sy = sres[31:16];
    assign sz = sres[15:0];

    function automatic void fill_exp_sh(input logic mode);
        int k, rep;
        exp_sh.delete();
        if (mode) begin
            for (int i = 0; i < N; i++) exp_sh.push_back(i > W - 1 ? W - 1 : i);
        end else begin
            k = 1;
            rep = 4;
            while (exp_sh.size() < N) begin
                exp_sh.push_back(k > W - 1 ? W - 1 : k);
                if (k == rep && exp_sh.size() < N) begin
                    exp_sh.push_back(k > W - 1 ? W - 1 : k);
                    rep = 3 * rep + 1;
                end
                k++;
            end
        end
    endfunction

    function automatic logic [47:0] ref_op(input logic mode, vec, input logic [15:0] x0, y0, z0);
        logic signed [15:0] x, y, z;
        logic [47:0] r;
        logic d;
        x = x0;
        y = y0;
        z = z0;
        fill_exp_sh(mode);
        for (int i = 0; i < N; i++) begin
            d = vec ? (y < 0) : (z >= 0);
            r = stage_f(x, y, z, d, mode, 4'(exp_sh[i]), 4'(exp_sh[i]));
            x = r[47:32];
            y = r[31:16];
            z = r[15:0];
        end
        return {x, y, z};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    task automatic check_near(input string tag, input logic [15:0] obs, input int target, input int tol);
        int diff;
        diff = int'($signed(obs)) - target;
        if (diff < 0) diff = -diff;
        n_total++;
        assert ((diff <= tol) === 1'b1) n_pass++;
        else $error("FAIL %s: got %0d expected %0d +-%0d", tag, $signed(obs), target, tol);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic mode, vec, input logic [15:0] x, y, z);
        i_mode = mode;
        i_vector = vec;
        i_x = x;
        i_y = y;
        i_z = z;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic wait_done(input bit log_sh, output int lat);
        lat = 0;
        got_sh.delete();
        while (!o_valid && lat < 100) begin
            if (log_sh) got_sh.push_back(int'(o_stage_shift));
            tick();
            lat++;
        end
    endtask

    task automatic finish_op();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic mode, vec, input logic [15:0] x, y, z);
        check(tag, {16'h0, o_x, o_y, o_z}, {16'h0, ref_op(mode, vec, x, y, z)});
    endtask

    initial begin
        int lat;
        logic [15:0] hx, hy, hz, rx, ry, rz;
        logic [47:0] held;
        logic rm, rv;

        i_valid = 1'b0;
        i_ready = 1'b0;
        i_mode = 1'b0;
        i_vector = 1'b0;
        i_x = '0;
        i_y = '0;
        i_z = '0;
        #12;
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_valid_busy", {62'h0, o_valid, o_busy}, 64'd0);
        check("rst_regs", {16'h0, o_x, o_y, o_z}, 64'd0);
        check("rst_shift", 64'(o_stage_shift), 64'd0);
        rst_n = 1'b1;
        tick();

        // circular vectoring: atan(1) accumulates in z
        start_op(1'b1, 1'b1, 16'h2000, 16'h2000, 16'h0000);
        wait_done(1'b0, lat);
        check("cv_latency", 64'(lat), 64'(N));
        check_near("cv_z_pi4", o_z, 16'h1922, 4);
        check_near("cv_y_zero", o_y, 0, 4);
        check_result("cv_exact", 1'b1, 1'b1, 16'h2000, 16'h2000, 16'h0000);
        finish_op();

        // circular rotation of (1/K, 0) by pi/4
        start_op(1'b1, 1'b0, 16'h136F, 16'h0000, 16'h1922);
        wait_done(1'b0, lat);
        check_near("cr_x", o_x, 16'h16A1, 4);
        check_near("cr_y", o_y, 16'h16A1, 4);
        check_result("cr_exact", 1'b1, 1'b0, 16'h136F, 16'h0000, 16'h1922);
        finish_op();

        // hyperbolic rotation with shift logging
        start_op(1'b0, 1'b0, 16'h2000, 16'h0000, 16'h0800);
        wait_done(1'b1, lat);
        check("hy_latency", 64'(lat), 64'(N));
        fill_exp_sh(1'b0);
        check("hy_shift_count", 64'(got_sh.size()), 64'(N));
        for (int i = 0; i < N && i < got_sh.size(); i++)
            check($sformatf("hy_shift[%0d]", i), 64'(got_sh[i]), 64'(exp_sh[i]));
        check_result("hy_exact", 1'b0, 1'b0, 16'h2000, 16'h0000, 16'h0800);

        // hold in DONE with a new operand offered; it must not be taken
        hx = 16'h0F00;
        hy = 16'h0000;
        hz = 16'hF400;
        i_mode = 1'b1;
        i_vector = 1'b0;
        i_x = hx;
        i_y = hy;
        i_z = hz;
        i_valid = 1'b1;
        held = {o_x, o_y, o_z};
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_flags", {61'h0, o_valid, o_ready, o_busy}, {61'h0, 3'b101});
            check("hold_data", {16'h0, o_x, o_y, o_z}, {16'h0, held});
        end

        // back-to-back: i_valid stays high across the result handshake
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("b2b_idle", {62'h0, o_valid, o_ready}, 64'd1);
        tick();
        i_valid = 1'b0;
        check("b2b_accept", {15'h0, o_busy, o_ready, o_x, o_y, o_z}, {15'h0, 2'b10, hx, hy, hz});
        wait_done(1'b0, lat);
        check("b2b_latency", 64'(lat), 64'(N));
        check_result("b2b_exact", 1'b1, 1'b0, hx, hy, hz);
        finish_op();

        // asynchronous reset at RUN step 7, then a clean op
        start_op(1'b1, 1'b1, 16'h1800, 16'hF000, 16'h0100);
        for (int i = 0; i < 7; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_flags", {61'h0, o_ready, o_valid, o_busy}, {61'h0, 3'b100});
        check("arst_regs", {16'h0, o_x, o_y, o_z}, 64'd0);
        check("arst_shift", 64'(o_stage_shift), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start_op(1'b0, 1'b1, 16'h1C00, 16'h0600, 16'h0000);
        wait_done(1'b0, lat);
        check("post_rst_latency", 64'(lat), 64'(N));
        check_result("post_rst_exact", 1'b0, 1'b1, 16'h1C00, 16'h0600, 16'h0000);
        finish_op();

        for (int t = 0; t < 12; t++) begin
            rm = 1'($urandom_range(0, 1));
            rv = 1'($urandom_range(0, 1));
            rx = 16'($urandom_range(0, 16'h3000)) - 16'h1800;
            ry = 16'($urandom_range(0, 16'h3000)) - 16'h1800;
            rz = 16'($urandom_range(0, 16'h3000)) - 16'h1800;
            start_op(rm, rv, rx, ry, rz);
            wait_done(1'b0, lat);
            check($sformatf("rnd%0d_latency", t), 64'(lat), 64'(N));
            check_result($sformatf("rnd%0d_exact", t), rm, rv, rx, ry, rz);
            finish_op();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
